// File: rtl/parking_pkg.sv
// Shared definitions for the parking billing stage: fee FSM state encoding,
// plate-type constants, slot count, fee ceiling and the slot-index helper.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } fee_state_t;

  localparam logic SEDAN = 1'b0;
  localparam logic SUV   = 1'b1;

  localparam int unsigned NUM_SLOTS = 14;
  localparam int unsigned FEE_MAX   = 255;

  // Slot index {floor-1, place}; only meaningful for floor 1..7.
  function automatic logic [3:0] slot_idx(input logic [2:0] floor, input logic place);
    return {floor - 3'd1, place};
  endfunction

endpackage

// File: rtl/parking_fee_unit_if.sv
// Event/result bundle between the lot controller and the billing stage.
//   master: drives park_* and leave_* events, observes billing results.
//   slave : the billing stage; drives leave_ready, fee, fee_valid,
//           slot_busy and error.
interface parking_fee_unit_if;
  import parking_pkg::*;

  logic                 park_valid;
  logic [2:0]           park_floor;
  logic                 park_place;
  logic                 park_type;
  logic                 leave_valid;
  logic [2:0]           leave_floor;
  logic                 leave_place;
  logic                 leave_ready;
  logic [7:0]           fee;
  logic                 fee_valid;
  logic [NUM_SLOTS-1:0] slot_busy;
  logic                 error;

  modport master (
    output park_valid, park_floor, park_place, park_type,
    output leave_valid, leave_floor, leave_place,
    input  leave_ready, fee, fee_valid, slot_busy, error
  );

  modport slave (
    input  park_valid, park_floor, park_place, park_type,
    input  leave_valid, leave_floor, leave_place,
    output leave_ready, fee, fee_valid, slot_busy, error
  );

endinterface

// File: rtl/fee_divider.sv
// Iterative divide of elapsed ticks by TICKS_PER_UNIT, counting whole
// billing units and saturating the count at 255.
//   clock, reset : rising-edge clock, async active-high reset
//   start        : load elapsed into the remainder and clear the unit count
//   elapsed      : stay length in ticks
//   done         : no further subtraction possible (combinational)
//   units        : billing units counted so far
module fee_divider #(
  parameter int unsigned TS_W           = 16,
  parameter int unsigned TICKS_PER_UNIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [TS_W-1:0] elapsed,
  output logic            done,
  output logic [7:0]      units
);

  localparam logic [TS_W-1:0] STEP = TS_W'(TICKS_PER_UNIT);

  logic [TS_W-1:0] rem;

  assign done = !((rem >= STEP) && (units != 8'hFF));

  // Once done the registers stop changing, so the result holds until the
  // next start without needing an explicit enable from the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem   <= '0;
      units <= '0;
    end else if (start) begin
      rem   <= elapsed;
      units <= '0;
    end else if (!done) begin
      rem   <= rem - STEP;
      units <= units + 8'd1;
    end
  end

endmodule

// File: rtl/parking_fee_unit.sv
// Parking billing stage. Timestamps each slot when a car is stored and,
// when a car is retrieved, divides the elapsed ticks into billing units,
// multiplies by the plate-type rate and reports a saturated 8-bit fee.
//   clock, reset : rising-edge clock, async active-high reset
//   bus (slave)  : park/leave events in; leave_ready, fee, fee_valid,
//                  slot_busy (index {floor-1, place}) and error out
module parking_fee_unit
  import parking_pkg::*;
#(
  parameter int unsigned TS_W           = 16,
  parameter int unsigned TICKS_PER_UNIT = 4,
  parameter int unsigned SEDAN_RATE     = 1,
  parameter int unsigned SUV_RATE       = 2
) (
  input  logic               clock,
  input  logic               reset,
  parking_fee_unit_if.slave  bus
);

  localparam logic [7:0] SEDAN_R = 8'(SEDAN_RATE);
  localparam logic [7:0] SUV_R   = 8'(SUV_RATE);

  fee_state_t           state;
  logic [TS_W-1:0]      tick;
  logic [NUM_SLOTS-1:0] busy;
  logic [TS_W-1:0]      ts    [NUM_SLOTS];
  logic                 ptype [NUM_SLOTS];
  logic [7:0]           rate_q;

  logic [3:0]           pidx;
  logic [3:0]           lidx;
  logic                 park_ok;
  logic                 park_bad;
  logic                 leave_ok;
  logic                 leave_bad;
  logic [TS_W-1:0]      elapsed;
  logic                 div_done;
  logic [7:0]           units;
  logic [15:0]          product;
  logic [7:0]           fee_next;

  // Event qualification. The floor check guards every slot lookup, so the
  // unused indices produced by floor 0 never reach state.
  always_comb begin
    pidx      = slot_idx(bus.park_floor, bus.park_place);
    lidx      = slot_idx(bus.leave_floor, bus.leave_place);
    leave_ok  = bus.leave_valid && (state == IDLE) &&
                (bus.leave_floor != 3'd0) && busy[lidx];
    leave_bad = bus.leave_valid && !leave_ok;
    park_ok   = bus.park_valid && (bus.park_floor != 3'd0) && !busy[pidx] &&
                !(leave_ok && (pidx == lidx));
    park_bad  = bus.park_valid && !park_ok;
  end

  // Modulo subtraction makes a counter wrap between park and leave harmless.
  assign elapsed = tick - ts[lidx];

  assign product  = {8'd0, units} * {8'd0, rate_q};
  assign fee_next = (product > 16'(FEE_MAX)) ? 8'(FEE_MAX) : product[7:0];

  fee_divider #(
    .TS_W           (TS_W),
    .TICKS_PER_UNIT (TICKS_PER_UNIT)
  ) u_div (
    .clock   (clock),
    .reset   (reset),
    .start   (leave_ok),
    .elapsed (elapsed),
    .done    (div_done),
    .units   (units)
  );

  // Tick counter and slot bookkeeping. A slot is freed at leave acceptance,
  // so it may be parked into again while the fee is still being computed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick <= '0;
      busy <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        ts[i]    <= '0;
        ptype[i] <= SEDAN;
      end
    end else begin
      tick <= tick + TS_W'(1);
      if (leave_ok) begin
        busy[lidx] <= 1'b0;
      end
      if (park_ok) begin
        busy[pidx]  <= 1'b1;
        ts[pidx]    <= tick;
        ptype[pidx] <= bus.park_type;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rate_q          <= '0;
      bus.leave_ready <= 1'b1;
      bus.fee         <= '0;
      bus.fee_valid   <= 1'b0;
      bus.error       <= 1'b0;
    end else begin
      bus.fee_valid <= 1'b0;
      bus.error     <= park_bad || leave_bad;
      case (state)
        IDLE: begin
          if (leave_ok) begin
            rate_q          <= (ptype[lidx] == SUV) ? SUV_R : SEDAN_R;
            bus.leave_ready <= 1'b0;
            state           <= DIV;
          end
        end
        DIV: begin
          if (div_done) begin
            state <= DONE;
          end
        end
        DONE: begin
          bus.fee         <= fee_next;
          bus.fee_valid   <= 1'b1;
          bus.leave_ready <= 1'b1;
          state           <= IDLE;
        end
        default: begin
          bus.leave_ready <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end

  assign bus.slot_busy = busy;

endmodule

// File: tb/tb_parking_fee_unit.sv
module tb_parking_fee_unit;
  import parking_pkg::*;

  localparam int TPU     = 4;
  localparam int R_SEDAN = 1;
  localparam int R_SUV   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] tb_tick;
  int          errors = 0;
  int          checks = 0;

  // Reference model: occupancy, entry tick and plate type per slot.
  bit          occ [14];
  logic [15:0] ent [14];
  bit          typ [14];

  parking_fee_unit_if bus ();

  parking_fee_unit #(
    .TS_W           (16),
    .TICKS_PER_UNIT (4),
    .SEDAN_RATE     (1),
    .SUV_RATE       (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) tb_tick <= '0;
    else       tb_tick <= tb_tick + 16'd1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input int f, input int p);
    return (f - 1) * 2 + p;
  endfunction

  function automatic logic [13:0] model_busy();
    logic [13:0] v;
    for (int i = 0; i < 14; i++) v[i] = occ[i];
    return v;
  endfunction

  task automatic cyc1();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc1();
  endtask

  task automatic do_park(input int f, input int p, input bit t);
    bit legal;
    legal = 1'b0;
    if (f >= 1) legal = !occ[idx_of(f, p)];
    bus.park_valid = 1'b1;
    bus.park_floor = 3'(f);
    bus.park_place = 1'(p);
    bus.park_type  = t;
    if (legal) begin
      occ[idx_of(f, p)] = 1'b1;
      ent[idx_of(f, p)] = tb_tick;
      typ[idx_of(f, p)] = t;
    end
    cyc1();
    bus.park_valid = 1'b0;
    check("park_error", 32'(bus.error), 32'(!legal));
    check("park_busy", 32'(bus.slot_busy), 32'(model_busy()));
  endtask

  task automatic do_leave(input int f, input int p, input bit repark);
    int          i, n, units, fee_e;
    logic [15:0] el;
    i     = idx_of(f, p);
    el    = tb_tick - ent[i];
    units = int'(el) / TPU;
    if (units > 255) units = 255;
    fee_e = units * (typ[i] ? R_SUV : R_SEDAN);
    if (fee_e > 255) fee_e = 255;
    bus.leave_valid = 1'b1;
    bus.leave_floor = 3'(f);
    bus.leave_place = 1'(p);
    occ[i] = 1'b0;
    cyc1();
    bus.leave_valid = 1'b0;
    check("leave_ready_low", 32'(bus.leave_ready), 32'd0);
    check("leave_error", 32'(bus.error), 32'd0);
    check("leave_busy", 32'(bus.slot_busy), 32'(model_busy()));
    n = 0;
    if (repark) begin
      bus.park_valid = 1'b1;
      bus.park_floor = 3'(f);
      bus.park_place = 1'(p);
      bus.park_type  = 1'b1;
      occ[i] = 1'b1;
      ent[i] = tb_tick;
      typ[i] = 1'b1;
      cyc1();
      bus.park_valid = 1'b0;
      n = 1;
      check("repark_busy", 32'(bus.slot_busy), 32'(model_busy()));
      check("repark_error", 32'(bus.error), 32'd0);
    end
    while (bus.fee_valid !== 1'b1 && n < 300) begin
      cyc1();
      n++;
    end
    check("fee_latency", 32'(n), 32'(units + 2));
    check("fee_value", 32'(bus.fee), 32'(fee_e));
    check("ready_with_valid", 32'(bus.leave_ready), 32'd1);
    cyc1();
    check("fee_valid_pulse", 32'(bus.fee_valid), 32'd0);
    check("fee_held", 32'(bus.fee), 32'(fee_e));
  endtask

  task automatic do_bad_leave(input int f, input int p);
    bus.leave_valid = 1'b1;
    bus.leave_floor = 3'(f);
    bus.leave_place = 1'(p);
    cyc1();
    bus.leave_valid = 1'b0;
    check("bad_leave_error", 32'(bus.error), 32'd1);
    check("bad_leave_busy", 32'(bus.slot_busy), 32'(model_busy()));
    check("bad_leave_ready", 32'(bus.leave_ready), 32'd1);
    cyc1();
    check("bad_leave_error_pulse", 32'(bus.error), 32'd0);
    check("bad_leave_no_fee", 32'(bus.fee_valid), 32'd0);
  endtask

  initial begin
    int f1, p1, f2, p2, n, seen;
    bit t1, t2;

    bus.park_valid  = 1'b0;
    bus.park_floor  = '0;
    bus.park_place  = 1'b0;
    bus.park_type   = 1'b0;
    bus.leave_valid = 1'b0;
    bus.leave_floor = '0;
    bus.leave_place = 1'b0;
    for (int i = 0; i < 14; i++) begin
      occ[i] = 1'b0;
      ent[i] = '0;
      typ[i] = 1'b0;
    end

    // Reset values
    @(posedge clock);
    #1;
    check("rst_fee", 32'(bus.fee), 32'd0);
    check("rst_fee_valid", 32'(bus.fee_valid), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_leave_ready", 32'(bus.leave_ready), 32'd1);
    check("rst_slot_busy", 32'(bus.slot_busy), 32'd0);
    reset = 1'b0;

    // Sedan: elapsed 8 -> fee 2, latency 4
    do_park(1, 0, 1'b0);
    idle(7);
    do_leave(1, 0, 1'b0);

    // SUV: elapsed 10 -> fee 4, with a re-park into the slot during DIV
    do_park(7, 1, 1'b1);
    idle(9);
    do_leave(7, 1, 1'b1);

    // Illegal events
    do_bad_leave(3, 0);
    do_park(0, 0, 1'b0);
    cyc1();
    check("park0_error_pulse", 32'(bus.error), 32'd0);
    do_park(7, 1, 1'b0);
    cyc1();
    check("occupied_error_pulse", 32'(bus.error), 32'd0);
    bus.park_valid  = 1'b1;
    bus.park_floor  = 3'd0;
    bus.leave_valid = 1'b1;
    bus.leave_floor = 3'd4;
    bus.leave_place = 1'b1;
    cyc1();
    bus.park_valid  = 1'b0;
    bus.leave_valid = 1'b0;
    check("dual_error", 32'(bus.error), 32'd1);
    cyc1();
    check("dual_error_single", 32'(bus.error), 32'd0);
    check("dual_busy", 32'(bus.slot_busy), 32'(model_busy()));

    // Saturation: sedan units clamp, SUV product clamp
    do_park(1, 1, 1'b0);
    idle(1999);
    do_leave(1, 1, 1'b0);
    do_park(6, 0, 1'b1);
    idle(599);
    do_leave(6, 0, 1'b0);

    // Randomized overlapping stays
    for (int r = 0; r < 6; r++) begin
      do begin
        f1 = int'($urandom_range(1, 7));
        p1 = int'($urandom_range(0, 1));
      end while (occ[idx_of(f1, p1)]);
      t1 = 1'($urandom_range(0, 1));
      do_park(f1, p1, t1);
      do begin
        f2 = int'($urandom_range(1, 7));
        p2 = int'($urandom_range(0, 1));
      end while (occ[idx_of(f2, p2)]);
      t2 = 1'($urandom_range(0, 1));
      do_park(f2, p2, t2);
      idle(int'($urandom_range(0, 1100)));
      do_leave(f1, p1, 1'b0);
      idle(int'($urandom_range(0, 300)));
      do_leave(f2, p2, 1'b0);
    end

    // Tick wrap: park at 65530, leave at 2
    n = 0;
    while (tb_tick != 16'd65530 && n < 70000) begin
      cyc1();
      n++;
    end
    do_park(1, 0, 1'b0);
    idle(7);
    do_leave(1, 0, 1'b0);

    // Leave outside IDLE, then reset during DIV
    do_park(2, 1, 1'b0);
    idle(399);
    bus.leave_valid = 1'b1;
    bus.leave_floor = 3'd2;
    bus.leave_place = 1'b1;
    occ[idx_of(2, 1)] = 1'b0;
    cyc1();
    bus.leave_valid = 1'b0;
    check("mid_leave_ready", 32'(bus.leave_ready), 32'd0);
    idle(3);
    bus.leave_valid = 1'b1;
    bus.leave_floor = 3'd7;
    bus.leave_place = 1'b1;
    cyc1();
    bus.leave_valid = 1'b0;
    check("busy_leave_error", 32'(bus.error), 32'd1);
    check("busy_leave_slots", 32'(bus.slot_busy), 32'(model_busy()));
    idle(2);
    reset = 1'b1;
    #1;
    check("mid_rst_fee_valid", 32'(bus.fee_valid), 32'd0);
    check("mid_rst_leave_ready", 32'(bus.leave_ready), 32'd1);
    check("mid_rst_slot_busy", 32'(bus.slot_busy), 32'd0);
    check("mid_rst_fee", 32'(bus.fee), 32'd0);
    for (int i = 0; i < 14; i++) occ[i] = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b0;
    seen = 0;
    repeat (300) begin
      cyc1();
      if (bus.fee_valid === 1'b1) seen++;
    end
    check("mid_rst_no_fee_valid", 32'(seen), 32'd0);
    check("mid_rst_fee_held", 32'(bus.fee), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
